// File: rtl/inst_mem_loader.sv
// Instruction memory loader: turns a host byte stream (count byte N, then N
// big-endian 32-bit words) into write strobes for the CPU instruction memory.
// The CPU is held in reset until a complete, well-formed program has landed.
module inst_mem_loader #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // words_left must hold DEPTH itself, one more than the largest address.
    localparam int WL_W = $clog2(DEPTH + 1);

    // The idle counter only needs to reach TIMEOUT-1: the cycle that would
    // take it to TIMEOUT is the cycle that aborts the load instead.
    localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t              state_q,      state_d;
    logic [31:0]         word_q,       word_d;
    logic [ADDR_W-1:0]   addr_q,       addr_d;
    logic [1:0]          byte_idx_q,   byte_idx_d;
    logic [WL_W-1:0]     words_left_q, words_left_d;
    logic [IDLE_W-1:0]   idle_cnt_q,   idle_cnt_d;

    logic                rx_ready_q,   rx_ready_d;
    logic                mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,   mem_addr_d;
    logic [31:0]         mem_wdata_q,  mem_wdata_d;
    logic                cpu_hold_q,   cpu_hold_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                err_q,        err_d;

    logic                accept;
    logic                hdr_bad;
    logic [31:0]         word_shifted;

    // rx_ready is registered, so a byte is taken exactly when the host sees
    // ready high and drives valid on the same edge.
    assign accept       = rx_valid && rx_ready_q;
    assign hdr_bad      = (rx_data == 8'd0) || (32'(rx_data) > 32'(DEPTH));
    assign word_shifted = {word_q[23:0], rx_data};

    // Next-state and datapath logic; outputs are derived from the next state
    // so that every output comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        addr_d       = addr_q;
        byte_idx_d   = byte_idx_q;
        words_left_d = words_left_q;
        idle_cnt_d   = idle_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR;
                end
            end

            S_HDR: begin
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = S_ERR;
                    end else begin
                        words_left_d = WL_W'(rx_data);
                        addr_d       = '0;
                        byte_idx_d   = '0;
                        idle_cnt_d   = '0;
                        state_d      = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    word_d     = word_shifted;
                    idle_cnt_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        mem_addr_d  = addr_q;
                        mem_wdata_d = word_shifted;
                        state_d     = S_WRITE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if ((TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST)) begin
                    state_d = S_ERR;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end

            S_WRITE: begin
                addr_d       = addr_q + 1'b1;
                words_left_d = words_left_q - 1'b1;
                byte_idx_d   = '0;
                idle_cnt_d   = '0;
                if (words_left_q == WL_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
        mem_we_d   = (state_d == S_WRITE);
        busy_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_hold_d = (state_d != S_DONE);
    end

    // State and output registers; reset parks the loader idle with the CPU held.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            addr_q       <= '0;
            byte_idx_q   <= '0;
            words_left_q <= '0;
            idle_cnt_q   <= '0;
            rx_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            byte_idx_q   <= byte_idx_d;
            words_left_q <= words_left_d;
            idle_cnt_q   <= idle_cnt_d;
            rx_ready_q   <= rx_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader. Two instances share the stimulus: one with
// the default idle timeout and one with a short timeout for the abort case.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        rx_ready,  mem_we,  cpu_hold,  busy,  done,  err;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;

    logic        rx_ready_t8, mem_we_t8, cpu_hold_t8, busy_t8, done_t8, err_t8;
    logic [3:0]  mem_addr_t8;
    logic [31:0] mem_wdata_t8;

    int          errors = 0;
    int          checks = 0;
    int          wr_count = 0;
    int          wr_count_t8 = 0;
    int          next_addr = 0;
    int          order_errs = 0;
    logic [31:0] mem_model [16];

    inst_mem_loader #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(64)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    inst_mem_loader #(.DEPTH(16), .ADDR_W(4), .TIMEOUT(8)) dut_t8 (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready_t8),
        .mem_we    (mem_we_t8),
        .mem_addr  (mem_addr_t8),
        .mem_wdata (mem_wdata_t8),
        .cpu_hold  (cpu_hold_t8),
        .busy      (busy_t8),
        .done      (done_t8),
        .err       (err_t8)
    );

    always #5 clk = ~clk;

    // Memory model: capture each write strobe once, mid-cycle, and note any out-of-order address.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            mem_model[mem_addr] = mem_wdata;
            if (int'(mem_addr) != next_addr) order_errs++;
            next_addr++;
            wr_count++;
        end
        if (mem_we_t8 === 1'b1) wr_count_t8++;
    end

    // Hard stop in case the sequence stalls somewhere unexpected.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Present one byte and hold it until the loader takes it; returns on the
    // falling edge right after the accepting edge with rx_valid dropped.
    task automatic applyStimulus(input logic [7:0] b);
        bit taken;
        taken    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100 && !taken; i++) begin
            if (rx_ready === 1'b1) taken = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        checkOutput("byte_accepted", 32'(taken), 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 3; k >= 0; k--) begin
            applyStimulus(w[8*k +: 8]);
            idle_cycles(gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic logic [31:0] t3_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        return {b, b ^ 8'h5A, 8'hC3, ~b};
    endfunction

    initial begin
        sys_rst  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;

        // Reset values appear without any clock edge.
        #1 sys_rst = 1'b1;
        #1;
        checkOutput("rst_cpu_hold", cpu_hold, 1);
        checkOutput("rst_rx_ready", rx_ready, 0);
        checkOutput("rst_busy",     busy,     0);
        checkOutput("rst_done",     done,     0);
        checkOutput("rst_err",      err,      0);
        checkOutput("rst_mem_we",   mem_we,   0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_wdata",    mem_wdata, 0);

        // start held across an edge while reset is high must not begin a load.
        start = 1'b1;
        @(negedge clk);
        sys_rst = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        checkOutput("rst_start_ready", rx_ready, 0);
        checkOutput("rst_start_busy",  busy,     0);

        // T1: two-word program.
        $display("[TB] T1 two-word load");
        pulse_start();
        checkOutput("t1_hdr_ready", rx_ready, 1);
        checkOutput("t1_hdr_busy",  busy,     1);
        checkOutput("t1_hdr_hold",  cpu_hold, 1);
        applyStimulus(8'h02);
        send_word(32'h0840_0005, 0);
        checkOutput("t1_w0_we",    mem_we,    1);
        checkOutput("t1_w0_addr",  mem_addr,  0);
        checkOutput("t1_w0_data",  mem_wdata, 32'h0840_0005);
        checkOutput("t1_w0_ready", rx_ready,  0);
        send_word(32'h1082_0003, 0);
        checkOutput("t1_w1_we",   mem_we,    1);
        checkOutput("t1_w1_addr", mem_addr,  1);
        checkOutput("t1_w1_data", mem_wdata, 32'h1082_0003);
        @(negedge clk);
        checkOutput("t1_done",     done,     1);
        checkOutput("t1_hold",     cpu_hold, 0);
        checkOutput("t1_busy",     busy,     0);
        checkOutput("t1_we_low",   mem_we,   0);
        checkOutput("t1_wr_count", wr_count, 2);
        checkOutput("t1_order",    order_errs, 0);

        // Bytes offered in DONE are ignored.
        rx_data  = 8'hFF;
        rx_valid = 1'b1;
        idle_cycles(2);
        rx_valid = 1'b0;
        checkOutput("done_ready",    rx_ready, 0);
        checkOutput("done_sticky",   done,     1);
        checkOutput("done_no_write", wr_count, 2);

        // T2: illegal headers.
        $display("[TB] T2 bad headers");
        pulse_start();
        checkOutput("t2_done_clr", done,     0);
        checkOutput("t2_hold",     cpu_hold, 1);
        applyStimulus(8'h00);
        checkOutput("t2_err_zero",   err,      1);
        checkOutput("t2_hold_zero",  cpu_hold, 1);
        checkOutput("t2_busy_zero",  busy,     0);
        checkOutput("t2_ready_zero", rx_ready, 0);
        pulse_start();
        checkOutput("t2_err_clr",   err,      0);
        checkOutput("t2_ready_hdr", rx_ready, 1);
        applyStimulus(8'h11);
        checkOutput("t2_err_big",  err,      1);
        checkOutput("t2_hold_big", cpu_hold, 1);
        idle_cycles(2);
        checkOutput("t2_no_write", wr_count, 2);

        // T3: full-depth load with 3-cycle gaps between every byte.
        $display("[TB] T3 full depth with gaps");
        wr_count   = 0;
        next_addr  = 0;
        order_errs = 0;
        pulse_start();
        applyStimulus(8'h10);
        idle_cycles(3);
        for (int i = 0; i < 16; i++) send_word(t3_word(i), 3);
        checkOutput("t3_done",     done,       1);
        checkOutput("t3_err",      err,        0);
        checkOutput("t3_hold",     cpu_hold,   0);
        checkOutput("t3_wr_count", wr_count,   16);
        checkOutput("t3_order",    order_errs, 0);
        checkOutput("t3_mem0",     mem_model[0],  32'h005A_C3FF);
        checkOutput("t3_mem9",     mem_model[9],  32'h0953_C3F6);
        checkOutput("t3_mem15",    mem_model[15], 32'h0F55_C3F0);
        checkOutput("t3_t8_done",  done_t8,    1);
        checkOutput("t3_t8_err",   err_t8,     0);

        // T4: stream stalls mid-word; only the short-timeout instance aborts.
        $display("[TB] T4 idle timeout");
        wr_count_t8 = 0;
        pulse_start();
        applyStimulus(8'h01);
        applyStimulus(8'hAA);
        applyStimulus(8'hBB);
        idle_cycles(7);
        checkOutput("t4_err_early", err_t8,      0);
        checkOutput("t4_ready_pre", rx_ready_t8, 1);
        idle_cycles(1);
        checkOutput("t4_err",       err_t8,      1);
        checkOutput("t4_ready",     rx_ready_t8, 0);
        checkOutput("t4_busy",      busy_t8,     0);
        checkOutput("t4_hold",      cpu_hold_t8, 1);
        checkOutput("t4_no_write",  wr_count_t8, 0);
        checkOutput("t4_long_err",  err,         0);
        checkOutput("t4_long_busy", busy,        1);

        // T5: asynchronous reset with a partial word in flight, then reload.
        $display("[TB] T5 reset mid-load");
        #1 sys_rst = 1'b1;
        #1;
        checkOutput("t5_ready", rx_ready, 0);
        checkOutput("t5_busy",  busy,     0);
        checkOutput("t5_we",    mem_we,   0);
        checkOutput("t5_done",  done,     0);
        checkOutput("t5_hold",  cpu_hold, 1);
        #1 sys_rst = 1'b0;
        @(negedge clk);
        wr_count  = 0;
        next_addr = 0;
        pulse_start();
        applyStimulus(8'h01);
        send_word(32'h1234_5678, 0);
        checkOutput("t5_we_w",   mem_we,    1);
        checkOutput("t5_addr",   mem_addr,  0);
        checkOutput("t5_data",   mem_wdata, 32'h1234_5678);
        @(negedge clk);
        checkOutput("t5_done_w",  done,         1);
        checkOutput("t5_count",   wr_count,     1);
        checkOutput("t5_mem0",    mem_model[0], 32'h1234_5678);

        // T6: start during DATA is ignored; start after done restarts.
        $display("[TB] T6 start while busy");
        wr_count   = 0;
        next_addr  = 0;
        order_errs = 0;
        pulse_start();
        applyStimulus(8'h02);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        pulse_start();
        checkOutput("t6_ready_kept", rx_ready, 1);
        checkOutput("t6_busy_kept",  busy,     1);
        checkOutput("t6_err_none",   err,      0);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        checkOutput("t6_w0_addr", mem_addr,  0);
        checkOutput("t6_w0_data", mem_wdata, 32'h1122_3344);
        send_word(32'h5566_7788, 0);
        checkOutput("t6_w1_addr", mem_addr,  1);
        checkOutput("t6_w1_data", mem_wdata, 32'h5566_7788);
        @(negedge clk);
        checkOutput("t6_done",  done,       1);
        checkOutput("t6_count", wr_count,   2);
        checkOutput("t6_order", order_errs, 0);
        pulse_start();
        checkOutput("t6_done_clr", done,     0);
        checkOutput("t6_hold",     cpu_hold, 1);
        checkOutput("t6_ready",    rx_ready, 1);
        checkOutput("t6_busy",     busy,     1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
